btn_event: RTL and testbench

Button gesture classifier that sits directly downstream of the button debouncer. It consumes the debounced level and the shared 1 ms `tick` and emits single-cycle event pulses: press, release, short click, double click, long press, and auto-repeat while held. Downstream control FSMs (mode select, counter set, and similar) act on these pulses instead of decoding raw levels.

---
 rtl/btn_event.sv | 155 +++++++++++++++
 tb/tb_btn_event.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// Button gesture classifier: turns a debounced level plus a 1 ms tick into
// single-cycle press/release/short/double/long/repeat event pulses.
module btn_event #(
    parameter int LONG_MS   = 1000,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic clk_100Mhz,
    input  logic rst,
    input  logic tick,
    input  logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    // state  | meaning
    // IDLE   | released, no gesture in progress
    // PRESS1 | first press held, timing toward long press
    // WAIT2  | released after a short press, double-click window open
    // PRESS2 | second press of a double click held, no long detection
    // LONG   | long hold, emitting auto-repeat
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    localparam logic [10:0] LONG_LAST   = 11'(LONG_MS - 1);
    localparam logic [10:0] DOUBLE_LAST = 11'(DOUBLE_MS - 1);
    localparam logic [10:0] REPEAT_LAST = 11'(REPEAT_MS - 1);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        btn_d_q;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        short_q, short_d;
    logic        double_q, double_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;
    logic        rise, fall;

    assign rise = btn_db & ~btn_d_q;
    assign fall = ~btn_db & btn_d_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS1;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            // Edge checks come first so a coincident tick is neither counted
            // nor allowed to fire a timeout.
            S_PRESS1: begin
                if (fall) begin
                    state_d   = S_WAIT2;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (tick && cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_d  = S_PRESS2;
                    cnt_d    = '0;
                    press_d  = 1'b1;
                    double_d = 1'b1;
                end else if (tick && cnt_q == DOUBLE_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (tick && cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            btn_d_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_d_q   <= btn_db;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            double_q  <= double_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign double_pulse  = double_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: directed gestures and random button activity, scored
// against a gesture-level reference model through an expected-event queue.
module tb_btn_event;

    localparam int LONG_T   = 10;
    localparam int DOUBLE_T = 5;
    localparam int REPEAT_T = 3;

    logic clk_100Mhz = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic btn_db = 1'b0;
    logic press_pulse, release_pulse, short_pulse, double_pulse, long_pulse, repeat_pulse;

    btn_event #(.LONG_MS(LONG_T), .DOUBLE_MS(DOUBLE_T), .REPEAT_MS(REPEAT_T)) dut (
        .clk_100Mhz   (clk_100Mhz),
        .rst          (rst),
        .tick         (tick),
        .btn_db       (btn_db),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    // Event vector bit order: {press, release, short, double, long, repeat}
    typedef struct {
        int         cyc;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   tph = 0;

    // Reference model: gesture phase plus ticks elapsed within that phase.
    // ph: 0 released, 1 first hold, 2 double window, 3 second hold, 4 long hold
    int   ph = 0;
    int   elapsed = 0;
    logic prev_lvl = 1'b0;

    always @(posedge clk_100Mhz) begin
        logic [5:0] ev;
        logic went_down, went_up;
        cyc = cyc + 1;
        ev = 6'b0;
        if (rst) begin
            ph = 0;
            elapsed = 0;
            prev_lvl = 1'b0;
        end else begin
            went_down = btn_db && !prev_lvl;
            went_up   = !btn_db && prev_lvl;
            prev_lvl  = btn_db;
            case (ph)
                0: if (went_down) begin ph = 1; elapsed = 0; ev = 6'b100000; end
                1: if (went_up) begin
                       ph = 2; elapsed = 0; ev = 6'b010000;
                   end else if (tick) begin
                       elapsed = elapsed + 1;
                       if (elapsed == LONG_T) begin ph = 4; elapsed = 0; ev = 6'b000010; end
                   end
                2: if (went_down) begin
                       ph = 3; elapsed = 0; ev = 6'b100100;
                   end else if (tick) begin
                       elapsed = elapsed + 1;
                       if (elapsed == DOUBLE_T) begin ph = 0; elapsed = 0; ev = 6'b001000; end
                   end
                3: if (went_up) begin ph = 0; ev = 6'b010000; end
                default: if (went_up) begin
                       ph = 0; elapsed = 0; ev = 6'b010000;
                   end else if (tick) begin
                       elapsed = elapsed + 1;
                       if (elapsed == REPEAT_T) begin elapsed = 0; ev = 6'b000001; end
                   end
            endcase
        end
        if (ev != 6'b0) q.push_back('{cyc: cyc, v: ev});
    end

    always @(negedge clk_100Mhz) begin
        logic [5:0] dv;
        exp_t e;
        if (mon_en) begin
            dv = {press_pulse, release_pulse, short_pulse, double_pulse, long_pulse, repeat_pulse};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL missed_event cyc=%0d got=none exp=%b", e.cyc, e.v);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checks = checks + 1;
                if (dv !== e.v) begin
                    errors = errors + 1;
                    $display("FAIL event cyc=%0d got=%b exp=%b", cyc, dv, e.v);
                end
            end else if (dv !== 6'b0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL spurious_event cyc=%0d got=%b exp=000000", cyc, dv);
            end
        end
    end

    task automatic step(input logic b, input logic t, input logic r);
        @(posedge clk_100Mhz);
        #2;
        btn_db = b;
        tick   = t;
        rst    = r;
    endtask

    // Periodic tick: one tick every 4 clocks
    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            step(b, (tph == 3), 1'b0);
            tph = (tph + 1) % 4;
        end
    endtask

    // Exactly n ticks, each ending a 4-clock group
    task automatic ticks_exact(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            step(b, 1'b0, 1'b0);
            step(b, 1'b0, 1'b0);
            step(b, 1'b0, 1'b0);
            step(b, 1'b1, 1'b0);
        end
        tph = 0;
    endtask

    initial begin
        logic [5:0] dv;
        repeat (2) @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
        dv = {press_pulse, release_pulse, short_pulse, double_pulse, long_pulse, repeat_pulse};
        checks = checks + 1;
        if (dv !== 6'b0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs got=%b exp=000000", dv);
        end
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // single click
        run(1'b1, 12); run(1'b0, 40);
        // double click
        run(1'b1, 8); run(1'b0, 8); run(1'b1, 8); run(1'b0, 40);
        // long hold with repeat
        run(1'b1, 80); run(1'b0, 40);
        // fall coincident with the long threshold tick
        step(1'b1, 1'b0, 1'b0); ticks_exact(1'b1, LONG_T - 1);
        step(1'b0, 1'b1, 1'b0); run(1'b0, 40);
        // second rise coincident with the double-window timeout tick
        step(1'b1, 1'b0, 1'b0); ticks_exact(1'b1, 2);
        step(1'b0, 1'b0, 1'b0); ticks_exact(1'b0, DOUBLE_T - 1);
        step(1'b1, 1'b1, 1'b0); ticks_exact(1'b1, 2);
        step(1'b0, 1'b0, 1'b0); run(1'b0, 40);
        // reset during a long hold, button kept pressed
        run(1'b1, 60); step(1'b1, 1'b0, 1'b1); run(1'b1, 60); run(1'b0, 40);

        // random activity with random tick spacing and occasional resets
        for (int s = 0; s < 150; s++) begin
            logic b;
            int   len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 50);
            for (int i = 0; i < len; i++)
                step(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
        end
        run(1'b0, 80);
        repeat (2) @(negedge clk_100Mhz);

        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL leftover_events got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
